fetch_decode_buffer: RTL

//   Receiving end of the fetch-stage output (instruction + cur_pc): a 2-entry
//   in-order skid buffer between iFetch and decode (IF/ID boundary).

---
 rtl/fetch_decode_buffer_if.sv | 31 +++
 rtl/fetch_decode_buffer.sv | 116 +++++++++++
 2 files changed

// File: rtl/fetch_decode_buffer_if.sv
// IF/ID boundary bundle: fetch-side valid/ready push, flush, decode-side
// valid/ready pop plus status. The buffer sits on the slave side.
interface fetch_decode_buffer_if #(
  parameter int INSTR_W = 32,
  parameter int ADDR_W  = 64
);
  logic               in_valid;
  logic               in_ready;
  logic [INSTR_W-1:0] in_instruction;
  logic [ADDR_W-1:0]  in_pc;
  logic               flush;
  logic               out_valid;
  logic               out_ready;
  logic [INSTR_W-1:0] out_instruction;
  logic [ADDR_W-1:0]  out_pc;
  logic [ADDR_W-1:0]  out_pc_plus4;
  logic [1:0]         occupancy;
  logic [7:0]         flush_count;

  modport master (
    output in_valid, in_instruction, in_pc, flush, out_ready,
    input  in_ready, out_valid, out_instruction, out_pc, out_pc_plus4,
           occupancy, flush_count
  );

  modport slave (
    input  in_valid, in_instruction, in_pc, flush, out_ready,
    output in_ready, out_valid, out_instruction, out_pc, out_pc_plus4,
           occupancy, flush_count
  );
endinterface

// File: rtl/fetch_decode_buffer.sv
// Two-entry in-order skid buffer between instruction fetch and decode.
// Entry 0 always holds the oldest instruction (the head shown to decode);
// entry 1 holds the younger one when the buffer is full. A flush empties
// the buffer and drops any instruction offered in the same cycle.
module fetch_decode_buffer #(
  parameter int                 INSTR_W   = 32,
  parameter int                 ADDR_W    = 64,
  parameter logic [INSTR_W-1:0] NOP_INSTR = 32'hD503201F
) (
  input logic                  clk,
  input logic                  reset,
  fetch_decode_buffer_if.slave bus
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t             state;
  logic [7:0]         flush_cnt;
  logic [INSTR_W-1:0] slot0_instr;
  logic [ADDR_W-1:0]  slot0_pc;
  logic [INSTR_W-1:0] slot1_instr;
  logic [ADDR_W-1:0]  slot1_pc;
  logic               accept;
  logic               consume;
  logic               ready;
  logic               valid;

  // Saturating event counter step: sticks at 255.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Handshake qualifiers; in_ready looks only at state and reset so the
  // fetch side never waits on decode combinationally.
  always_comb begin
    ready   = !reset && (state != FULL);
    valid   = (state != EMPTY) && !bus.flush;
    accept  = bus.in_valid && ready;
    consume = valid && bus.out_ready;
  end

  // Occupancy FSM and flush counter; flush overrides every transition.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= EMPTY;
      flush_cnt <= 8'd0;
    end else if (bus.flush) begin
      state <= EMPTY;
      if ((state != EMPTY) || bus.in_valid) begin
        flush_cnt <= sat_inc8(flush_cnt);
      end
    end else begin
      case (state)
        EMPTY: if (accept) state <= ONE;
        ONE: begin
          if (accept && !consume)      state <= FULL;
          else if (!accept && consume) state <= EMPTY;
        end
        FULL:    if (consume) state <= ONE;
        default: state <= EMPTY;
      endcase
    end
  end

  // Entry storage: head stays in slot 0, so a pop from FULL shifts the
  // younger entry forward and an accept+consume in ONE lands in slot 0.
  always_ff @(posedge clk) begin
    if (!bus.flush) begin
      case (state)
        EMPTY: begin
          if (accept) begin
            slot0_instr <= bus.in_instruction;
            slot0_pc    <= bus.in_pc;
          end
        end
        ONE: begin
          if (accept && consume) begin
            slot0_instr <= bus.in_instruction;
            slot0_pc    <= bus.in_pc;
          end else if (accept) begin
            slot1_instr <= bus.in_instruction;
            slot1_pc    <= bus.in_pc;
          end
        end
        FULL: begin
          if (consume) begin
            slot0_instr <= slot1_instr;
            slot0_pc    <= slot1_pc;
          end
        end
        default: ;
      endcase
    end
  end

  // Decode-facing view of the head; NOP at PC 0 when nothing is held.
  always_comb begin
    bus.in_ready    = ready;
    bus.out_valid   = valid;
    bus.occupancy   = state;
    bus.flush_count = flush_cnt;
    if (state == EMPTY) begin
      bus.out_instruction = NOP_INSTR;
      bus.out_pc          = '0;
    end else begin
      bus.out_instruction = slot0_instr;
      bus.out_pc          = slot0_pc;
    end
    bus.out_pc_plus4 = bus.out_pc + ADDR_W'(4);
  end

endmodule
